load_store_unit: RTL and testbench

Multi-cycle RV32I load/store unit between the execute stage and the data-memory bus. Accepts one load or store per `start`, drives a req/gnt/rvalid memory handshake, generates byte enables and lane-replicated store data, and aligns and sign- or zero-extends load data. `rdata` drives the load-data input of the writeback 4:1 result mux.

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/load_align.sv | 46 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state enum, legality helpers.
package rv32i_pkg;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;
   localparam logic [2:0] F3Sb  = 3'b000;
   localparam logic [2:0] F3Sh  = 3'b001;
   localparam logic [2:0] F3Sw  = 3'b010;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } lsu_state_e;

   // Unsigned variants exist only for loads.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3Lb, F3Lh, F3Lw: return 1'b1;
         F3Lbu, F3Lhu:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane logic: byte enables, store-data replication, load extract and extension.
module load_align
   import rv32i_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] store_data,
   output logic [31:0] load_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic        sign_ext;

   always_comb begin
      case (addr_lo)
         2'b00:   lane_byte = mem_rdata[7:0];
         2'b01:   lane_byte = mem_rdata[15:8];
         2'b10:   lane_byte = mem_rdata[23:16];
         default: lane_byte = mem_rdata[31:24];
      endcase
      lane_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      sign_ext  = ~funct3[2];

      be         = 4'b1111;
      store_data = wdata;
      load_data  = mem_rdata;
      case (funct3[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_lo;
            store_data = {4{wdata[7:0]}};
            load_data  = {{24{sign_ext & lane_byte[7]}}, lane_byte};
         end
         2'b01: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            store_data = {2{wdata[15:0]}};
            load_data  = {{16{sign_ext & lane_half[15]}}, lane_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/gnt/rvalid bus FSM with timeout and registered outputs.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned halfword/word accesses before the bus.
module load_store_unit
   import rv32i_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            we_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic [31:0]     rdata_q, rdata_d;
   logic            busy_q, done_q, err_q, mem_req_q, mem_we_q;
   logic [3:0]      mem_be_q;
   logic [31:0]     mem_addr_q, mem_wdata_q;

   logic            accept, fault, legal, bad_align;
   logic [2:0]      align_f3;
   logic [1:0]      align_addr;
   logic [3:0]      align_be;
   logic [31:0]     align_wdata, align_rdata;

   assign legal = funct3_legal(we, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
   assign bad_align = misaligned(funct3[1:0], addr[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   // Live request fields feed the aligner in IDLE; latched fields once the access is underway.
   assign align_f3   = (state_q == StIdle) ? funct3 : funct3_q;
   assign align_addr = (state_q == StIdle) ? addr[1:0] : addr_lo_q;

   load_align u_load_align (
      .funct3     (align_f3),
      .addr_lo    (align_addr),
      .wdata      (wdata),
      .mem_rdata  (mem_rdata),
      .be         (align_be),
      .store_data (align_wdata),
      .load_data  (align_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      accept  = 1'b0;
      fault   = 1'b0;
      // Saturates so a late grant still leaves the remaining budget exhausted.
      cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (!legal || bad_align) begin
                  state_d = StDone;
                  fault   = 1'b1;
               end else begin
                  state_d = StReq;
                  accept  = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         StReq: begin
            cnt_d = cnt_inc;
            if (mem_gnt) begin
               state_d = StWait;
            end else if (cnt_q == CntMax) begin
               state_d = StDone;
               fault   = 1'b1;
            end
         end
         StWait: begin
            cnt_d = cnt_inc;
            if (mem_rvalid) begin
               state_d = StDone;
               if (!we_q) rdata_d = align_rdata;
            end else if (cnt_q == CntMax) begin
               state_d = StDone;
               fault   = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         busy_q    <= (state_d != StIdle);
         done_q    <= (state_d == StDone);
         err_q     <= fault;
         mem_req_q <= (state_d == StReq);
         mem_we_q  <= (state_d == StReq) && (accept ? we : we_q);
         if (accept) begin
            we_q        <= we;
            funct3_q    <= funct3;
            addr_lo_q   <= addr[1:0];
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_be_q    <= align_be;
            mem_wdata_q <= we ? align_wdata : 32'h0;
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic reference model of the access rules.
module tb_load_store_unit;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] rdata_m = 32'h0;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .we         (we),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .rdata      (rdata),
      .err        (err),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int size_m(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic int offset_m(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_m(f3);
      return (int'(a % 4) / sz) * sz;
   endfunction

   function automatic bit legal_m(input logic w, input logic [2:0] f3);
      if (w) return f3 <= 3'd2;
      return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic bit misal_m(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a % size_m(f3)) != 0;
`else
      return (f3 != f3) || (a != a);
`endif
   endfunction

   function automatic logic [3:0] be_m(input logic [2:0] f3, input logic [31:0] a);
      int v = ((1 << size_m(f3)) - 1) << offset_m(f3, a);
      return v[3:0];
   endfunction

   function automatic logic [31:0] store_m(input logic [2:0] f3, input logic [31:0] w);
      case (size_m(f3))
         1:       return (w & 32'hFF) * 32'h0101_0101;
         2:       return (w & 32'hFFFF) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      int    bits = 8 * size_m(f3);
      longint v = (longint'(rd) >> (8 * offset_m(f3, a))) & ((64'd1 << bits) - 1);
      if (bits < 32 && f3 < 3'd4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   // g/r: cycles the bus holds off gnt and rvalid (-1 = never).
   task automatic run_op(input logic op_we, input logic [2:0] op_f3, input logic [31:0] op_addr,
                         input logic [31:0] op_wdata, input int g, input int r,
                         input logic [31:0] resp, input bit noisy);
      bit   bad, err_exp, got_done, granted, saw_req;
      int   done_exp, reqcnt, waitcnt;
      bad      = !legal_m(op_we, op_f3) || misal_m(op_f3, op_addr);
      got_done = 0;
      granted  = 0;
      saw_req  = 0;
      reqcnt   = 0;
      waitcnt  = 0;
      if (bad) begin
         done_exp = 1;
         err_exp  = 1;
      end else if (g < 0 || r < 0 || g + 1 + r > int'(T) - 1) begin
         done_exp = T + 1;
         err_exp  = 1;
      end else begin
         done_exp = g + 3 + r;
         err_exp  = 0;
         if (!op_we) rdata_m = load_m(op_f3, op_addr, resp);
      end

      @(negedge clk);
      start  = 1'b1;
      we     = op_we;
      funct3 = op_f3;
      addr   = op_addr;
      wdata  = op_wdata;
      @(posedge clk);
      #1;
      start = 1'b0;
      addr  = $urandom();
      wdata = $urandom();
      for (int cyc = 1; cyc <= 30 && !got_done; cyc++) begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom();
         start      = 1'b0;
         if (done) begin
            got_done = 1;
            check_eq("latency", cyc, done_exp);
            check_eq("err", err, err_exp);
            check_eq("rdata", rdata, rdata_m);
            check_eq("busy_done", busy, 1);
         end else begin
            check_eq("busy", busy, 1);
            if (mem_req) begin
               saw_req = 1;
               check_eq("mem_addr", mem_addr, op_addr & 32'hFFFF_FFFC);
               check_eq("mem_be", mem_be, be_m(op_f3, op_addr));
               check_eq("mem_we", mem_we, op_we);
               if (op_we) check_eq("mem_wdata", mem_wdata, store_m(op_f3, op_wdata));
               if (reqcnt == g) begin
                  mem_gnt = 1'b1;
                  granted = 1;
               end
               reqcnt++;
               mem_rvalid = noisy & $urandom_range(0, 1);
            end else if (granted) begin
               check_eq("mem_req_wait", mem_req, 0);
               if (waitcnt == r) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = resp;
               end
               waitcnt++;
            end
            if (noisy && cyc == 2) begin
               start  = 1'b1;
               we     = ~we;
               funct3 = 3'($urandom());
               addr   = $urandom();
            end
         end
      end
      check_eq("done_seen", got_done, 1);
      check_eq("req_seen", saw_req, !bad);
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      check_eq("done_pulse", done, 0);
      check_eq("busy_after", busy, 0);
      check_eq("err_after", err, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_err"}, err, 0);
      check_eq({tag, "_req"}, mem_req, 0);
      check_eq({tag, "_we"}, mem_we, 0);
      check_eq({tag, "_be"}, mem_be, 0);
      check_eq({tag, "_addr"}, mem_addr, 0);
      check_eq({tag, "_wdata"}, mem_wdata, 0);
      check_eq({tag, "_rdata"}, rdata, 0);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 check_zero_outputs("reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
      check_eq("lw_value", rdata, 32'hDEAD_BEEF);
      run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 0);
      check_eq("lb_value", rdata, 32'hFFFF_FF80);
      run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 0);
      check_eq("lbu_value", rdata, 32'h0000_0080);
      run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8012_3456, 0);
      check_eq("lhu_value", rdata, 32'h0000_8012);
      run_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 2, 0, 32'h0, 0);
      run_op(1'b0, 3'b010, 32'h300, 32'h0, -1, 0, 32'h1111_1111, 0);
      check_eq("timeout_keeps", rdata, 32'h0000_8012);
      run_op(1'b0, 3'b010, 32'h304, 32'h0, 0, -1, 32'h2222_2222, 0);
      run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h3333_3333, 0);
      run_op(1'b0, 3'b011, 32'h400, 32'h0, 0, 0, 32'h4444_4444, 0);
      run_op(1'b0, 3'b110, 32'h400, 32'h0, 0, 0, 32'h4444_4444, 0);
      run_op(1'b1, 3'b111, 32'h400, 32'h0, 0, 0, 32'h4444_4444, 0);
      run_op(1'b1, 3'b100, 32'h400, 32'h0, 0, 0, 32'h4444_4444, 0);

      for (int i = 0; i < 60; i++) begin
         int g, r;
         g = $urandom_range(0, 7) == 0 ? -1 : int'($urandom_range(0, 2));
         r = (g >= 0) ? int'($urandom_range(0, 2 - g)) : 0;
         if ($urandom_range(0, 7) == 0) r = -1;
         run_op(1'($urandom_range(0, 1)), 3'($urandom()), $urandom(), $urandom(), g, r,
                $urandom(), 1);
      end

      // Reset in WAIT, then a stray rvalid must not complete anything.
      @(negedge clk);
      start  = 1'b1;
      we     = 1'b0;
      funct3 = 3'b010;
      addr   = 32'h40;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check_eq("rst_req", mem_req, 1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check_eq("rst_wait_busy", busy, 1);
      rst = 1'b1;
      #1 check_zero_outputs("midrst");
      rdata_m = 32'h0;
      @(negedge clk);
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         check_eq("late_done", done, 0);
         check_eq("late_busy", busy, 0);
         check_eq("late_rdata", rdata, rdata_m);
      end
      run_op(1'b0, 3'b001, 32'h506, 32'h0, 1, 1, 32'h8765_4321, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
